// File: rtl/nn_pkg.sv
// Shared fixed-point types for the neuron datapath: signed Q(INTEGER_WIDTH).(FRACTION_WIDTH) words
// and the feeder state encoding.
package nn_pkg;
  // Integer/fraction split of the shared neuron number format.
  localparam int INTEGER_WIDTH  = 8;
  localparam int FRACTION_WIDTH = 8;
  localparam int W              = INTEGER_WIDTH + FRACTION_WIDTH;

  typedef logic signed [W-1:0] fixed_t;

  typedef enum logic [1:0] {
    LOADING,
    FIRING,
    WAITING,
    PRESENTING
  } feeder_state_t;
endpackage

// File: rtl/neuron_feeder_if.sv
// Feeder bus: serial sample input, parallel operand/start output to the neuron,
// result capture from the neuron and the downstream valid/ready result port.
interface neuron_feeder_if #(
  parameter int NUM_INPUTS = 16
);
  import nn_pkg::*;

  logic                    in_valid;
  fixed_t                  in_data;
  logic                    in_ready;
  fixed_t [NUM_INPUTS-1:0] inputs;
  logic                    inputs_ready;
  fixed_t                  result;
  logic                    result_ready;
  logic                    out_valid;
  fixed_t                  out_data;
  logic                    out_ready;
  logic                    timeout_error;

  modport master (
    output in_valid, in_data, result, result_ready, out_ready,
    input  in_ready, inputs, inputs_ready, out_valid, out_data, timeout_error
  );

  modport slave (
    input  in_valid, in_data, result, result_ready, out_ready,
    output in_ready, inputs, inputs_ready, out_valid, out_data, timeout_error
  );
endinterface

// File: rtl/neuron_feeder.sv
// Gathers NUM_INPUTS serial samples, fires the neuron, captures its result and presents it downstream.
// Optional watchdog in WAITING enabled by defining NEURON_FEEDER_TIMEOUT_EN.
module neuron_feeder
  import nn_pkg::*;
#(
  parameter int NUM_INPUTS     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic            clock,
  input logic            reset_n,
  neuron_feeder_if.slave bus
);
  localparam int            CW   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS - 1);

  feeder_state_t           state;
  feeder_state_t           state_nxt;
  logic [CW-1:0]           count;
  fixed_t [NUM_INPUTS-1:0] inputs_q;
  fixed_t                  out_q;
  logic                    accept;
  logic                    capture;
  logic                    timeout_hit;
  logic                    watchdog_expired;

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      LOADING: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          if (count == LAST) state_nxt = FIRING;
        end
      end
      FIRING: state_nxt = WAITING;
      WAITING: begin
        if (bus.result_ready) begin
          capture   = 1'b1;
          state_nxt = PRESENTING;
        end else if (watchdog_expired) begin
          timeout_hit = 1'b1;
          state_nxt   = LOADING;
        end
      end
      PRESENTING: begin
        if (bus.out_ready) state_nxt = LOADING;
      end
      default: state_nxt = LOADING;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= LOADING;
      count    <= '0;
      inputs_q <= '0;
      out_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        inputs_q[count] <= bus.in_data;
        count           <= (count == LAST) ? '0 : count + CW'(1);
      end
      if (capture) out_q <= bus.result;
    end
  end

`ifdef NEURON_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;
  logic          timeout_q;

  // wait_cnt holds the number of WAITING cycles already elapsed without a result.
  assign watchdog_expired = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != WAITING)       wait_cnt <= '0;
      else if (!watchdog_expired) wait_cnt <= wait_cnt + TW'(1);
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign bus.timeout_error = timeout_q;
`else
  assign watchdog_expired  = 1'b0;
  assign bus.timeout_error = 1'b0;
`endif

  assign bus.in_ready     = (state == LOADING);
  assign bus.inputs_ready = (state == FIRING);
  assign bus.out_valid    = (state == PRESENTING);
  assign bus.out_data     = out_q;
  assign bus.inputs       = inputs_q;
endmodule

// File: doc/neuron_feeder.md
NEURON_FEEDER -- requirements
Module: neuron_feeder

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 16: number of values gathered per neuron evaluation (>=1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: watchdog limit in WAITING (used only under REQ-027).
REQ-003 SHALL define W = INTEGER_WIDTH + FRACTION_WIDTH, signed fixed point [INTEGER_WIDTH-1:-FRACTION_WIDTH].
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  serial input sample valid.
REQ-007 in_data  in  W  serial input sample.
REQ-008 in_ready  out  1  feeder can accept a sample.
REQ-009 inputs  out  W x NUM_INPUTS  parallel operand array to neuron.
REQ-010 inputs_ready  out  1  one-cycle start pulse to neuron.
REQ-011 result  in  W  neuron output value.
REQ-012 result_ready  in  1  neuron output-valid pulse.
REQ-013 out_valid  out  1  captured result available downstream.
REQ-014 out_data  out  W  captured result.
REQ-015 out_ready  in  1  downstream accepts out_data.
REQ-016 timeout_error  out  1  sticky watchdog flag.

Function
REQ-017 SHALL implement FSM states LOADING, FIRING, WAITING, PRESENTING.
REQ-018 LOADING: in_ready=1; on in_valid, write in_data to inputs[count] and increment count; when the sample at index NUM_INPUTS-1 is accepted, go to FIRING and clear count.
REQ-019 FIRING: inputs_ready=1 for exactly one cycle, in_ready=0; unconditionally go to WAITING; latency from last accepted sample to inputs_ready = 1 cycle.
REQ-020 WAITING: in_ready=0; on result_ready, capture result into out_data and go to PRESENTING; out_valid rises the next cycle.
REQ-021 PRESENTING: out_valid=1, out_data stable; on out_ready go to LOADING (out_valid low the following cycle); no backpressure timeout.
REQ-022 inputs SHALL be written only in LOADING and SHALL be held stable from FIRING through PRESENTING.
REQ-023 result_ready outside WAITING SHALL be ignored; in_valid outside LOADING SHALL be ignored (not stored, not counted).
REQ-024 count width SHALL be max(1,$clog2(NUM_INPUTS)); NUM_INPUTS=1 goes LOADING->FIRING after one sample; count never exceeds NUM_INPUTS-1.
REQ-025 No arithmetic on data; values pass bit-exact, no saturation or resize.

Reset
REQ-026 On reset_n low (any state, mid-load included): state=LOADING, count=0, all inputs entries=0, out_data=0, inputs_ready=0, out_valid=0, timeout_error=0, in_ready=1 once reset released; partial loads discarded.

Configuration
REQ-027 With NEURON_FEEDER_TIMEOUT_EN defined: a cycle counter runs in WAITING; if result_ready not seen within TIMEOUT_CYCLES cycles, set timeout_error (sticky until reset) and return to LOADING with count=0.
REQ-028 Without NEURON_FEEDER_TIMEOUT_EN: no watchdog logic; timeout_error tied 0; WAITING is held indefinitely.

Structure
REQ-029 Shared package nn_pkg SHALL hold the fixed-point typedef (W-bit signed) and the feeder state enum; INTEGER_WIDTH/FRACTION_WIDTH come from the existing shared include.
REQ-030 No sub-module; watchdog is an inline counter.

Verification
REQ-031 NUM_INPUTS=4, feed 1.0,2.0,3.0,4.0 back-to-back -> inputs={1,2,3,4}, inputs_ready single pulse 1 cycle after 4th accept, in_ready low.
REQ-032 In WAITING, pulse result_ready with result=7.5 -> out_valid next cycle, out_data=7.5; hold out_ready=0 for 5 cycles -> out_data stable; out_ready=1 -> LOADING, in_ready=1.
REQ-033 in_valid gaps (valid every 3rd cycle) and stray in_valid during WAITING -> only LOADING samples stored, order preserved.
REQ-034 Assert reset_n low after 2 of 4 samples -> all outputs zero; next 4 samples form a fresh array starting at index 0.
REQ-035 Stray result_ready pulse in LOADING -> ignored, out_valid stays 0.
REQ-036 With NEURON_FEEDER_TIMEOUT_EN, TIMEOUT_CYCLES=8, no result_ready -> timeout_error=1 after 8 WAITING cycles, state LOADING, flag persists until reset.
